sprite_blitter: RTL and testbench

Parametrised sprite drawing engine for the VGA framebuffer path. On a `start` pulse it walks a 2^SPR_W_LOG2 × 2^SPR_H_LOG2 sprite stored in an external synchronous ROM and emits one framebuffer write per cycle at a latched screen origin. Compared with the fixed 32×64 graphing unit, it adds:
- colour-key transparency;
- screen-edge clipping;
- horizontal mirroring;
- an erase mode that repaints the sprite footprint with a background colour.

It sits between game logic and the VGA adapter write port.

---
 rtl/sprite_blitter_if.sv | 36 +++
 rtl/sprite_blitter.sv | 142 ++++++++++++++
 tb/tb_sprite_blitter.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/sprite_blitter_if.sv
// Sprite blitter bus: draw request, sprite ROM port
// and framebuffer write port.
interface sprite_blitter_if #(
  parameter int SPR_W_LOG2 = 5,
  parameter int SPR_H_LOG2 = 6,
  parameter int COLOUR_W   = 3
);
  logic                           start;
  logic [8:0]                     x_in;
  logic [7:0]                     y_in;
  logic                           mirror;
  logic                           erase;
  logic [COLOUR_W-1:0]            bg_colour;
  logic [SPR_W_LOG2+SPR_H_LOG2-1:0] rom_addr;
  logic [COLOUR_W-1:0]            rom_data;
  logic [8:0]                     x_out;
  logic [7:0]                     y_out;
  logic [COLOUR_W-1:0]            colour_out;
  logic                           writeEn;
  logic                           busy;
  logic                           done;

  modport slave (
    input  start, x_in, y_in, mirror,
    input  erase, bg_colour, rom_data,
    output rom_addr, x_out, y_out,
    output colour_out, writeEn, busy, done
  );

  modport master (
    output start, x_in, y_in, mirror,
    output erase, bg_colour, rom_data,
    input  rom_addr, x_out, y_out,
    input  colour_out, writeEn, busy, done
  );
endinterface

// File: rtl/sprite_blitter.sv
// Sprite blitter: walks a sprite ROM and emits one
// framebuffer write per cycle with key/clip/mirror/erase.
module sprite_blitter #(
  parameter int SPR_W_LOG2 = 5,
  parameter int SPR_H_LOG2 = 6,
  parameter int SCREEN_W   = 320,
  parameter int SCREEN_H   = 240,
  parameter int COLOUR_W   = 3,
  parameter int KEY_COLOUR = 0
) (
  input logic clk,
  input logic reset,
  sprite_blitter_if.slave bus
);
  localparam int AW = SPR_W_LOG2 + SPR_H_LOG2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t              r_state;
  logic [AW-1:0]       r_cnt;
  logic                r_drain;
  logic [8:0]          r_x0;
  logic [7:0]          r_y0;
  logic                r_mirror;
  logic                r_erase;
  logic [COLOUR_W-1:0] r_bg;
  logic                r_busy;
  logic                r_done;

  logic                r_s1_v;
  logic [9:0]          r_s1_x;
  logic [8:0]          r_s1_y;
  logic [8:0]          r_x_out;
  logic [7:0]          r_y_out;
  logic [COLOUR_W-1:0] r_colour;
  logic                r_we;

  logic [SPR_W_LOG2-1:0] w_col;
  logic [SPR_H_LOG2-1:0] w_row;
  logic [SPR_W_LOG2-1:0] w_col_src;
  logic [9:0]            w_x_sum;
  logic [8:0]            w_y_sum;
  logic                  w_opaque;
  logic                  w_onscreen;

  assign w_col     = r_cnt[SPR_W_LOG2-1:0];
  assign w_row     = r_cnt[AW-1:SPR_W_LOG2];
  assign w_col_src = r_mirror ? ~w_col : w_col;
  assign w_x_sum   = {1'b0, r_x0} + 10'(w_col);
  assign w_y_sum   = {1'b0, r_y0} + 9'(w_row);

  assign w_opaque   = bus.rom_data
                   != COLOUR_W'(KEY_COLOUR);
  assign w_onscreen = (r_s1_x < 10'(SCREEN_W))
                   && (r_s1_y < 9'(SCREEN_H));

  assign bus.rom_addr = (r_state == S_RUN)
                      ? {w_row, w_col_src} : '0;

  assign bus.x_out      = r_x_out;
  assign bus.y_out      = r_y_out;
  assign bus.colour_out = r_colour;
  assign bus.writeEn    = r_we;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;

  // Control FSM: latch request, count pixels, drain, pulse done.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_drain  <= 1'b0;
      r_x0     <= '0;
      r_y0     <= '0;
      r_mirror <= 1'b0;
      r_erase  <= 1'b0;
      r_bg     <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_state  <= S_RUN;
            r_cnt    <= '0;
            r_x0     <= bus.x_in;
            r_y0     <= bus.y_in;
            r_mirror <= bus.mirror;
            r_erase  <= bus.erase;
            r_bg     <= bus.bg_colour;
            r_busy   <= 1'b1;
          end
        end
        S_RUN: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == '1) begin
            r_state <= S_DRAIN;
            r_drain <= 1'b0;
          end
        end
        S_DRAIN: begin
          r_drain <= 1'b1;
          if (r_drain) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Two-stage write pipeline aligned with the ROM latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_v   <= 1'b0;
      r_s1_x   <= '0;
      r_s1_y   <= '0;
      r_x_out  <= '0;
      r_y_out  <= '0;
      r_colour <= '0;
      r_we     <= 1'b0;
    end else begin
      r_s1_v   <= (r_state == S_RUN);
      r_s1_x   <= w_x_sum;
      r_s1_y   <= w_y_sum;
      r_x_out  <= r_s1_x[8:0];
      r_y_out  <= r_s1_y[7:0];
      r_colour <= r_erase ? r_bg : bus.rom_data;
      r_we     <= r_s1_v && w_opaque && w_onscreen;
    end
  end
endmodule

// File: tb/tb_sprite_blitter.sv
// Directed bench for sprite_blitter on a 4x2 sprite
// with a synchronous ROM model.
module tb_sprite_blitter;
  logic clk;
  logic reset;
  int   tests;
  int   fails;

  logic [2:0] rom [8];
  int exp_we   [13];
  int exp_x    [13];
  int exp_y    [13];
  int exp_c    [13];
  int exp_addr [13];

  sprite_blitter_if #(
    .SPR_W_LOG2(2), .SPR_H_LOG2(1), .COLOUR_W(3)
  ) bif ();

  sprite_blitter #(
    .SPR_W_LOG2(2), .SPR_H_LOG2(1),
    .SCREEN_W(320), .SCREEN_H(240),
    .COLOUR_W(3), .KEY_COLOUR(0)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) bif.rom_data <= rom[bif.rom_addr];

  task automatic check(input string tag, input int c,
                       input logic [31:0] obs,
                       input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h",
             tag, c, obs, expv);
    end
  endtask

  task automatic clear_exp();
    for (int c = 0; c < 13; c++) begin
      exp_we[c] = 0; exp_x[c] = 0; exp_y[c] = 0;
      exp_c[c] = 0; exp_addr[c] = 0;
    end
  endtask

  task automatic set_w(input int c, input int x,
                       input int y, input int col);
    exp_we[c] = 1; exp_x[c] = x; exp_y[c] = y;
    exp_c[c] = col;
  endtask

  task automatic set_addr(input bit m);
    int mtab [8];
    mtab = '{3, 2, 1, 0, 7, 6, 5, 4};
    for (int c = 1; c <= 8; c++)
      exp_addr[c] = m ? mtab[c-1] : c - 1;
  endtask

  task automatic load_rom();
    rom = '{3'd1, 3'd2, 3'd3, 3'd4,
            3'd5, 3'd6, 3'd7, 3'd1};
  endtask

  // Called at the negedge of cycle 0; returns at cycle 12.
  task automatic run_draw(input logic [8:0] x,
                          input logic [7:0] y,
                          input logic m, input logic e,
                          input logic [2:0] bg,
                          input bit hold);
    bif.start = 1'b1;
    bif.x_in = x; bif.y_in = y;
    bif.mirror = m; bif.erase = e; bif.bg_colour = bg;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      if (!hold || c >= 11) bif.start = 1'b0;
      bif.x_in = 9'h1ff; bif.y_in = 8'hff;
      bif.mirror = ~m; bif.erase = ~e;
      bif.bg_colour = ~bg;
      @(negedge clk);
      check("busy", c, 32'(bif.busy), 32'(c <= 11));
      check("done", c, 32'(bif.done), 32'(c == 11));
      check("rom_addr", c, 32'(bif.rom_addr), exp_addr[c]);
      check("writeEn", c, 32'(bif.writeEn), exp_we[c]);
      if (exp_we[c] != 0) begin
        check("x_out", c, 32'(bif.x_out), exp_x[c]);
        check("y_out", c, 32'(bif.y_out), exp_y[c]);
        check("colour", c, 32'(bif.colour_out), exp_c[c]);
      end
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    load_rom();
    reset = 1'b1;
    bif.start = 1'b0; bif.x_in = '0; bif.y_in = '0;
    bif.mirror = 1'b0; bif.erase = 1'b0;
    bif.bg_colour = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_x", 0, 32'(bif.x_out), 0);
    check("rst_y", 0, 32'(bif.y_out), 0);
    check("rst_col", 0, 32'(bif.colour_out), 0);
    check("rst_we", 0, 32'(bif.writeEn), 0);
    check("rst_busy", 0, 32'(bif.busy), 0);
    check("rst_done", 0, 32'(bif.done), 0);
    check("rst_addr", 0, 32'(bif.rom_addr), 0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_busy", 0, 32'(bif.busy), 0);

    // Basic draw at (10,20)
    clear_exp(); set_addr(1'b0);
    set_w(3, 10, 20, 1); set_w(4, 11, 20, 2);
    set_w(5, 12, 20, 3); set_w(6, 13, 20, 4);
    set_w(7, 10, 21, 5); set_w(8, 11, 21, 6);
    set_w(9, 12, 21, 7); set_w(10, 13, 21, 1);
    run_draw(9'd10, 8'd20, 1'b0, 1'b0, 3'd0, 1'b0);

    // Mirror with transparent ROM[1]
    rom[1] = 3'd0;
    clear_exp(); set_addr(1'b1);
    set_w(3, 0, 0, 4); set_w(4, 1, 0, 3);
    set_w(6, 3, 0, 1);
    set_w(7, 0, 1, 1); set_w(8, 1, 1, 7);
    set_w(9, 2, 1, 6); set_w(10, 3, 1, 5);
    run_draw(9'd0, 8'd0, 1'b1, 1'b0, 3'd0, 1'b0);

    // Clipping at the bottom-right corner
    load_rom();
    clear_exp(); set_addr(1'b0);
    set_w(3, 318, 239, 1); set_w(4, 319, 239, 2);
    run_draw(9'd318, 8'd239, 1'b0, 1'b0, 3'd0, 1'b0);

    // Erase with transparent ROM[5], start held high
    rom[5] = 3'd0;
    clear_exp(); set_addr(1'b0);
    set_w(3, 50, 100, 6); set_w(4, 51, 100, 6);
    set_w(5, 52, 100, 6); set_w(6, 53, 100, 6);
    set_w(7, 50, 101, 6);
    set_w(9, 52, 101, 6); set_w(10, 53, 101, 6);
    run_draw(9'd50, 8'd100, 1'b0, 1'b1, 3'd6, 1'b1);

    // Reset in cycle 5, restart in cycle 6
    load_rom();
    bif.start = 1'b1;
    bif.x_in = 9'd10; bif.y_in = 8'd20;
    bif.mirror = 1'b0; bif.erase = 1'b0;
    for (int c = 1; c <= 18; c++) begin
      @(posedge clk); #1;
      bif.start = (c == 6);
      reset = (c == 5);
      @(negedge clk);
      if (c == 5) begin
        check("mid_we", c, 32'(bif.writeEn), 1);
        check("mid_x", c, 32'(bif.x_out), 12);
      end
      if (c == 6) begin
        check("ab_we", c, 32'(bif.writeEn), 0);
        check("ab_busy", c, 32'(bif.busy), 0);
        check("ab_addr", c, 32'(bif.rom_addr), 0);
      end
      if (c >= 6)
        check("ab_done", c, 32'(bif.done), 32'(c == 17));
      if (c >= 7) begin
        check("re_busy", c, 32'(bif.busy), 32'(c <= 17));
        check("re_we", c, 32'(bif.writeEn),
              32'(c >= 9 && c <= 16));
      end
      if (c == 7)
        check("re_addr", c, 32'(bif.rom_addr), 0);
      if (c == 9) begin
        check("re_x", c, 32'(bif.x_out), 10);
        check("re_col", c, 32'(bif.colour_out), 1);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
